ftdi_fifo_bridge: RTL and testbench

Sits directly downstream of the FTDI 245 interface block, on the Mercurial side. It consumes received bytes over the four-phase rx_rq/rx_st handshake and buffers them in an RX FIFO for user logic. It drains a TX FIFO filled by user logic into the FTDI block over the tx_rq/tx_st handshake. User logic sees plain valid/ready byte streams with occupancy counts.

---
 rtl/ftdi_fifo_bridge.sv | 154 +++++++++++++++
 tb/tb_ftdi_fifo_bridge.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ftdi_fifo_bridge.sv
// Bridge between the FTDI 245 interface block and user logic: an RX FIFO filled over
// the rx_rq/rx_st four-phase handshake, and a TX FIFO drained over tx_rq/tx_st.
// User logic sees plain valid/ready byte streams plus occupancy counts.
module ftdi_fifo_bridge #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned TX_GAP     = 2
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_rq,
  output logic                  rx_st,
  output logic [7:0]            tx_data,
  output logic                  tx_rq,
  input  logic                  tx_st,
  output logic [7:0]            user_rx_data,
  output logic                  user_rx_valid,
  input  logic                  user_rx_ready,
  input  logic [7:0]            user_tx_data,
  input  logic                  user_tx_valid,
  output logic                  user_tx_ready,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic [DEPTH_LOG2:0]   tx_count
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;
  localparam int unsigned GapW  = $clog2(TX_GAP + 1) + 1;
  localparam logic [CntW-1:0] Full = CntW'(Depth);

  typedef enum logic [0:0] {RxIdle, RxWait} rx_state_e;
  typedef enum logic [1:0] {TxIdle, TxReq, TxWait, TxHold} tx_state_e;

  rx_state_e rx_state_q;
  tx_state_e tx_state_q;

  logic [7:0]            rx_mem [Depth];
  logic [7:0]            tx_mem [Depth];
  logic [DEPTH_LOG2-1:0] rx_wptr_q, rx_rptr_q, tx_wptr_q, tx_rptr_q;
  logic [CntW-1:0]       rx_count_q, tx_count_q;
  logic [GapW-1:0]       gap_q;

  logic rx_push, rx_pop, tx_push, tx_pop;

  // Push/pop decisions use only registered occupancy, so a same-cycle pop never frees
  // a slot for a same-cycle push.
  assign rx_push = (rx_state_q == RxIdle) && rx_rq && (rx_count_q != Full);
  assign rx_pop  = user_rx_ready && (rx_count_q != '0);
  assign tx_push = user_tx_valid && (tx_count_q != Full);
  assign tx_pop  = (tx_state_q == TxIdle) && (tx_count_q != '0);

  assign user_rx_data  = rx_mem[rx_rptr_q];
  assign user_rx_valid = (rx_count_q != '0);
  assign user_tx_ready = (tx_count_q != Full);
  assign rx_count      = rx_count_q;
  assign tx_count      = tx_count_q;

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clock_in) begin
    if (rx_push) rx_mem[rx_wptr_q] <= rx_data;
    if (tx_push) tx_mem[tx_wptr_q] <= user_tx_data;
  end

  // RX FIFO pointers and occupancy.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_count_q <= '0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
      if (rx_push && !rx_pop)      rx_count_q <= rx_count_q + 1'b1;
      else if (!rx_push && rx_pop) rx_count_q <= rx_count_q - 1'b1;
    end
  end

  // TX FIFO pointers and occupancy.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_count_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
      if (tx_push && !tx_pop)      tx_count_q <= tx_count_q + 1'b1;
      else if (!tx_push && tx_pop) tx_count_q <= tx_count_q - 1'b1;
    end
  end

  // RX handshake: acknowledge one byte per rx_rq assertion, hold until rx_rq drops.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      rx_state_q <= RxIdle;
      rx_st      <= 1'b0;
    end else begin
      unique case (rx_state_q)
        RxIdle: begin
          if (rx_push) begin
            rx_st      <= 1'b1;
            rx_state_q <= RxWait;
          end
        end
        RxWait: begin
          if (!rx_rq) begin
            rx_st      <= 1'b0;
            rx_state_q <= RxIdle;
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  // TX handshake: present head byte, wait for capture and release, then enforce a
  // low gap on tx_rq so the FTDI block sees it idle before the next request.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      tx_state_q <= TxIdle;
      tx_rq      <= 1'b0;
      tx_data    <= 8'h00;
      gap_q      <= '0;
    end else begin
      unique case (tx_state_q)
        TxIdle: begin
          if (tx_pop) begin
            tx_data    <= tx_mem[tx_rptr_q];
            tx_rq      <= 1'b1;
            tx_state_q <= TxReq;
          end
        end
        TxReq: begin
          if (tx_st) begin
            tx_rq      <= 1'b0;
            tx_state_q <= TxWait;
          end
        end
        TxWait: begin
          if (!tx_st) begin
            gap_q      <= GapW'(TX_GAP);
            tx_state_q <= TxHold;
          end
        end
        TxHold: begin
          if (gap_q == '0) tx_state_q <= TxIdle;
          else             gap_q      <= gap_q - 1'b1;
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ftdi_fifo_bridge.sv
// Directed bench for ftdi_fifo_bridge: RX/TX handshakes, backpressure, full FIFOs,
// concurrent traffic and asynchronous reset.
module tb_ftdi_fifo_bridge;

  localparam int unsigned TxGap = 2;

  logic       clock_in = 1'b0;
  logic       reset;
  logic [7:0] rx_data, tx_data, user_rx_data, user_tx_data;
  logic       rx_rq, rx_st, tx_rq, tx_st;
  logic       user_rx_valid, user_rx_ready, user_tx_valid, user_tx_ready;
  logic [4:0] rx_count, tx_count;

  int total = 0;
  int bad   = 0;

  ftdi_fifo_bridge #(.DEPTH_LOG2(4), .TX_GAP(TxGap)) dut (
    .clock_in      (clock_in),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_rq         (rx_rq),
    .rx_st         (rx_st),
    .tx_data       (tx_data),
    .tx_rq         (tx_rq),
    .tx_st         (tx_st),
    .user_rx_data  (user_rx_data),
    .user_rx_valid (user_rx_valid),
    .user_rx_ready (user_rx_ready),
    .user_tx_data  (user_tx_data),
    .user_tx_valid (user_tx_valid),
    .user_tx_ready (user_tx_ready),
    .rx_count      (rx_count),
    .tx_count      (tx_count)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  // Full four-phase RX handshake for one byte, bounded waits.
  task automatic rx_byte(input logic [7:0] b, input string tag);
    int n;
    rx_data = b;
    rx_rq   = 1'b1;
    n = 0;
    while (!rx_st && n < 40) begin step(); n++; end
    check({tag, " ack"}, 32'(rx_st), 32'd1);
    rx_rq = 1'b0;
    n = 0;
    while (rx_st && n < 40) begin step(); n++; end
    check({tag, " release"}, 32'(rx_st), 32'd0);
  endtask

  // Pop one RX byte and compare it.
  task automatic rx_pop(input logic [7:0] exp, input string tag);
    check({tag, " valid"}, 32'(user_rx_valid), 32'd1);
    check({tag, " data"}, 32'(user_rx_data), 32'(exp));
    user_rx_ready = 1'b1;
    step();
    user_rx_ready = 1'b0;
  endtask

  // Act as the FTDI block for one TX byte; gap returns the low samples seen first.
  task automatic tx_take(input logic [7:0] exp, input string tag, output int gap);
    int n;
    n = 0;
    while (!tx_rq && n < 60) begin step(); n++; end
    gap = n;
    check({tag, " rq"}, 32'(tx_rq), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check({tag, " data"}, 32'(tx_data), 32'(exp));
      step();
    end
    check({tag, " held"}, 32'(tx_rq), 32'd1);
    tx_st = 1'b1;
    step();
    check({tag, " rq drop"}, 32'(tx_rq), 32'd0);
    tx_st = 1'b0;
  endtask

  initial begin
    int gap;
    int acc;
    reset = 1'b1;
    rx_data = 8'h00; rx_rq = 1'b0; tx_st = 1'b0;
    user_rx_ready = 1'b0; user_tx_valid = 1'b0; user_tx_data = 8'h00;
    #12;
    check("rst rx_st", 32'(rx_st), 32'd0);
    check("rst tx_rq", 32'(tx_rq), 32'd0);
    check("rst tx_data", 32'(tx_data), 32'd0);
    check("rst rx_valid", 32'(user_rx_valid), 32'd0);
    check("rst tx_ready", 32'(user_tx_ready), 32'd1);
    check("rst rx_count", 32'(rx_count), 32'd0);
    check("rst tx_count", 32'(tx_count), 32'd0);
    @(negedge clock_in);
    reset = 1'b0;
    step();

    // Single RX byte with exact handshake timing.
    rx_data = 8'h55; rx_rq = 1'b1;
    step();
    check("rx1 st high", 32'(rx_st), 32'd1);
    check("rx1 valid", 32'(user_rx_valid), 32'd1);
    rx_rq = 1'b0;
    step();
    check("rx1 st low", 32'(rx_st), 32'd0);
    check("rx1 data", 32'(user_rx_data), 32'h55);
    check("rx1 count", 32'(rx_count), 32'd1);
    user_rx_ready = 1'b1;
    step();
    user_rx_ready = 1'b0;
    check("rx1 count after pop", 32'(rx_count), 32'd0);
    check("rx1 valid after pop", 32'(user_rx_valid), 32'd0);

    // RX backpressure: fill 16, 17th is held off until a pop.
    for (int i = 0; i < 16; i++) rx_byte(8'(i), "rxbp fill");
    check("rxbp count full", 32'(rx_count), 32'd16);
    rx_data = 8'h10; rx_rq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rxbp no ack", 32'(rx_st), 32'd0);
    end
    check("rxbp count held", 32'(rx_count), 32'd16);
    rx_pop(8'h00, "rxbp pop0");
    check("rxbp no ack on pop", 32'(rx_st), 32'd0);
    step();
    check("rxbp late ack", 32'(rx_st), 32'd1);
    rx_rq = 1'b0;
    step();
    check("rxbp count refill", 32'(rx_count), 32'd16);
    for (int i = 1; i <= 16; i++) rx_pop(8'(i), "rxbp drain");
    check("rxbp empty", 32'(rx_count), 32'd0);

    // TX burst of three bytes pushed back to back.
    user_tx_valid = 1'b1;
    user_tx_data = 8'hA1; step();
    user_tx_data = 8'hB2; step();
    user_tx_data = 8'hC3; step();
    user_tx_valid = 1'b0;
    tx_take(8'hA1, "txb a1", gap);
    tx_take(8'hB2, "txb b2", gap);
    check("txb gap1 ok", 32'(gap >= int'(TxGap)), 32'd1);
    tx_take(8'hC3, "txb c3", gap);
    check("txb gap2 ok", 32'(gap >= int'(TxGap)), 32'd1);
    for (int i = 0; i < 10; i++) step();
    check("txb idle", 32'(tx_rq), 32'd0);
    check("txb count", 32'(tx_count), 32'd0);

    // TX full with FTDI side stalled: 17 accepted, 18th ignored.
    acc = 0;
    for (int i = 0; i < 18; i++) begin
      user_tx_data  = 8'(8'h20 + i);
      user_tx_valid = 1'b1;
      if (user_tx_ready) acc++;
      step();
    end
    user_tx_valid = 1'b0;
    check("txf accepted", 32'(acc), 32'd17);
    check("txf count", 32'(tx_count), 32'd16);
    check("txf ready low", 32'(user_tx_ready), 32'd0);
    check("txf head out", 32'(tx_data), 32'h20);
    for (int i = 0; i < 17; i++) tx_take(8'(8'h20 + i), "txf drain", gap);
    for (int i = 0; i < 10; i++) step();
    check("txf no extra", 32'(tx_rq), 32'd0);
    check("txf count end", 32'(tx_count), 32'd0);

    // Concurrent traffic with simultaneous push/pop on both FIFOs.
    rx_byte(8'h30, "cc pre0");
    rx_byte(8'h31, "cc pre1");
    rx_data = 8'h32; rx_rq = 1'b1;
    user_rx_ready = 1'b1;
    user_tx_valid = 1'b1; user_tx_data = 8'h44;
    step();
    user_rx_ready = 1'b0;
    check("cc rx count", 32'(rx_count), 32'd2);
    check("cc rx head", 32'(user_rx_data), 32'h31);
    check("cc rx ack", 32'(rx_st), 32'd1);
    check("cc tx count1", 32'(tx_count), 32'd1);
    rx_rq = 1'b0;
    user_tx_data = 8'h45;
    step();
    user_tx_valid = 1'b0;
    check("cc tx count2", 32'(tx_count), 32'd1);
    check("cc tx rq", 32'(tx_rq), 32'd1);
    check("cc tx data", 32'(tx_data), 32'h44);
    fork
      begin
        int g;
        tx_take(8'h44, "cc tx44", g);
        tx_take(8'h45, "cc tx45", g);
      end
      begin
        rx_byte(8'h33, "cc rx33");
        rx_pop(8'h31, "cc pop31");
        rx_pop(8'h32, "cc pop32");
        rx_pop(8'h33, "cc pop33");
      end
    join
    for (int i = 0; i < 10; i++) step();
    check("cc rx end", 32'(rx_count), 32'd0);
    check("cc tx end", 32'(tx_count), 32'd0);

    // Asynchronous reset mid-handshake.
    rx_data = 8'h77; rx_rq = 1'b1;
    user_tx_valid = 1'b1; user_tx_data = 8'h88; step();
    user_tx_data = 8'h99; step();
    user_tx_valid = 1'b0;
    step();
    check("ar rx_st before", 32'(rx_st), 32'd1);
    check("ar tx_rq before", 32'(tx_rq), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("ar rx_st drop", 32'(rx_st), 32'd0);
    check("ar tx_rq drop", 32'(tx_rq), 32'd0);
    check("ar tx_data", 32'(tx_data), 32'd0);
    check("ar rx_count", 32'(rx_count), 32'd0);
    check("ar tx_count", 32'(tx_count), 32'd0);
    rx_rq = 1'b0;
    @(negedge clock_in);
    reset = 1'b0;
    step();
    check("ar tx_ready", 32'(user_tx_ready), 32'd1);
    check("ar rx_valid", 32'(user_rx_valid), 32'd0);
    for (int i = 0; i < 5; i++) step();
    check("ar tx quiet", 32'(tx_rq), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
